// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter, the caches and the memory model.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_pick2.sv
// Combinational 2-way winner select.
// DMEM_ARB_RR_EN: alternate on ties using last_grant; otherwise port 0 always wins.
module arb_pick2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

`ifdef DMEM_ARB_RR_EN
    always_comb begin
        if (req == 2'b11) begin
            grant = ~last_grant;
        end else begin
            grant = req[0] ? PORT_D : PORT_I;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = req[0] ? PORT_D : PORT_I;
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing the line-wide data memory between D-cache (port 0) and I-cache (port 1).
// Tie-break policy selected by DMEM_ARB_RR_EN (see arb_pick2).
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [LINE_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [LINE_W-1:0] m0_data_o,

    input  logic              m1_req_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LINE_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [LINE_W-1:0] m1_data_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_data_i,

    output logic              busy_o
);

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] rdata0_q, rdata0_d;
    logic [LINE_W-1:0] rdata1_q, rdata1_d;
    logic              win;

    arb_pick2 u_pick (
        .req        ({m1_req_i, m0_req_i}),
        .last_grant (last_q),
        .grant      (win)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            owner_q  <= PORT_D;
            last_q   <= PORT_I;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ARB_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    state_d = ARB_BUSY;
                    owner_d = win;
                    last_d  = win;
                    if (win == PORT_I) begin
                        write_d = m1_write_i;
                        addr_d  = m1_addr_i;
                        wdata_d = m1_data_i;
                    end else begin
                        write_d = m0_write_i;
                        addr_d  = m0_addr_i;
                        wdata_d = m0_data_i;
                    end
                end
            end
            ARB_BUSY: begin
                if (mem_ack_i) begin
                    state_d = ARB_DONE;
                    // Read lines land only in the owner's register; writes leave both untouched.
                    if (!write_q) begin
                        if (owner_q == PORT_I) begin
                            rdata1_d = mem_data_i;
                        end else begin
                            rdata0_d = mem_data_i;
                        end
                    end
                end
            end
            ARB_DONE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Enable and acks decode straight from registered state, so they stay glitch-free.
    assign mem_enable_o = (state_q == ARB_BUSY);
    assign mem_write_o  = write_q;
    assign mem_addr_o   = addr_q;
    assign mem_data_o   = wdata_q;
    assign m0_ack_o     = (state_q == ARB_DONE) && (owner_q == PORT_D);
    assign m1_ack_o     = (state_q == ARB_DONE) && (owner_q == PORT_I);
    assign m0_data_o    = rdata0_q;
    assign m1_data_o    = rdata1_q;
    assign busy_o       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, hand sequences, random traffic
// against a transaction-level model (winner rule, line memory, per-port returned data).
module tb_dmem_arbiter;

    typedef logic [255:0] line_t;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    typedef struct {
        bit          r0;
        bit          w0;
        logic [31:0] a0;
        line_t       d0;
        bit          r1;
        bit          w1;
        logic [31:0] a1;
        line_t       d1;
        int          lat;
        int          first;
        line_t       exp0;
        line_t       exp1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 1'b0, m0_write_i = 1'b0;
    logic [31:0] m0_addr_i = '0;
    line_t       m0_data_i = '0;
    logic        m0_ack_o;
    line_t       m0_data_o;
    logic        m1_req_i = 1'b0, m1_write_i = 1'b0;
    logic [31:0] m1_addr_i = '0;
    line_t       m1_data_i = '0;
    logic        m1_ack_o;
    line_t       m1_data_o;
    logic        mem_enable_o, mem_write_o;
    logic [31:0] mem_addr_o;
    line_t       mem_data_o;
    logic        mem_ack_i = 1'b0;
    line_t       mem_data_i = '0;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    line_t ref_mem [int unsigned];
    line_t exp_d [2];
    bit    last_grant;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
        .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_req_i(m1_req_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
        .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .busy_o(busy_o)
    );

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_a(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input line_t act, input line_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic line_t ref_read(input logic [31:0] addr);
        if (ref_mem.exists(int'(addr[31:5]))) return ref_mem[int'(addr[31:5])];
        return {8{addr}};
    endfunction

    task automatic wait_enable(output int n);
        n = 0;
        while (!mem_enable_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!mem_enable_o) check_b("enable_timeout", mem_enable_o, 1'b1);
    endtask

    task automatic drop_all();
        m0_req_i = 1'b0; m0_write_i = 1'b0; m0_addr_i = '0; m0_data_i = '0;
        m1_req_i = 1'b0; m1_write_i = 1'b0; m1_addr_i = '0; m1_data_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check_b({tag, "_enable"}, mem_enable_o, 1'b0);
        check_b({tag, "_write"}, mem_write_o, 1'b0);
        check_a({tag, "_addr"}, mem_addr_o, 32'h0);
        check_w({tag, "_wdata"}, mem_data_o, '0);
        check_b({tag, "_ack0"}, m0_ack_o, 1'b0);
        check_b({tag, "_ack1"}, m1_ack_o, 1'b0);
        check_w({tag, "_data0"}, m0_data_o, '0);
        check_w({tag, "_data1"}, m1_data_o, '0);
        check_b({tag, "_busy"}, busy_o, 1'b0);
    endtask

    // Drive one or two simultaneous requests and act as memory until every request is acked.
    task automatic serve(input vec_t v, input bit scramble, output int first_w);
        bit          pend [2];
        bit          wr [2];
        logic [31:0] ad [2];
        line_t       dt [2];
        int          w, n, served;
        line_t       rd;
        pend[0] = v.r0; wr[0] = v.w0; ad[0] = v.a0; dt[0] = v.d0;
        pend[1] = v.r1; wr[1] = v.w1; ad[1] = v.a1; dt[1] = v.d1;
        first_w = -1;
        served = 0;
        m0_req_i = v.r0; m0_write_i = v.w0; m0_addr_i = v.a0; m0_data_i = v.d0;
        m1_req_i = v.r1; m1_write_i = v.w1; m1_addr_i = v.a1; m1_data_i = v.d1;
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) w = (RR_MODE && last_grant == 1'b0) ? 1 : 0;
            else                    w = pend[0] ? 0 : 1;
            wait_enable(n);
            if (!mem_enable_o) begin
                drop_all();
                return;
            end
            if (served > 0) check_i("gap_cycles", n, 1);
            check_b("mem_write", mem_write_o, wr[w]);
            check_a("mem_addr", mem_addr_o, ad[w]);
            if (wr[w]) check_w("mem_wdata", mem_data_o, dt[w]);
            check_b("busy_in_txn", busy_o, 1'b1);
            if (scramble) begin
                if (w == 0) begin
                    m0_addr_i = $urandom; m0_write_i = ~m0_write_i; m0_data_i = rand_line();
                end else begin
                    m1_addr_i = $urandom; m1_write_i = ~m1_write_i; m1_data_i = rand_line();
                end
            end
            rd = wr[w] ? rand_line() : ref_read(ad[w]);
            repeat (v.lat) @(negedge clk);
            check_b("enable_held", mem_enable_o, 1'b1);
            check_a("addr_held", mem_addr_o, ad[w]);
            mem_ack_i = 1'b1;
            mem_data_i = rd;
            @(negedge clk);
            mem_ack_i = 1'b0;
            mem_data_i = rand_line();
            if (wr[w]) ref_mem[int'(ad[w][31:5])] = dt[w];
            else       exp_d[w] = rd;
            last_grant = w[0];
            if (first_w < 0) first_w = m1_ack_o ? 1 : (m0_ack_o ? 0 : -1);
            check_b("ack_winner", (w == 1) ? m1_ack_o : m0_ack_o, 1'b1);
            check_b("ack_other", (w == 1) ? m0_ack_o : m1_ack_o, 1'b0);
            check_w("data0", m0_data_o, exp_d[0]);
            check_w("data1", m1_data_o, exp_d[1]);
            check_b("enable_drop", mem_enable_o, 1'b0);
            if (w == 0) m0_req_i = 1'b0;
            else        m1_req_i = 1'b0;
            pend[w] = 1'b0;
            served++;
            @(negedge clk);
            check_b("ack0_pulse", m0_ack_o, 1'b0);
            check_b("ack1_pulse", m1_ack_o, 1'b0);
            check_b("busy_idle", busy_o, 1'b0);
        end
        drop_all();
    endtask

    initial begin
        vec_t  tbl [6];
        vec_t  v;
        int    fw, n;
        line_t a5, l1234, lcafe, rd;

        a5    = {32{8'hA5}};
        l1234 = {16{16'h1234}};
        lcafe = {16{16'hCAFE}};
        ref_mem[32'h40 >> 5] = a5;
        exp_d[0] = '0;
        exp_d[1] = '0;
        last_grant = 1'b1;

        tbl[0] = '{1,0,32'h40,'0,  0,0,32'h0,'0,     7, 0, a5, '0};
        tbl[1] = '{0,0,32'h0,'0,   1,1,32'h100,l1234, 3, 1, a5, '0};
        tbl[2] = '{0,0,32'h0,'0,   1,0,32'h100,'0,    2, 1, a5, l1234};
        tbl[3] = '{1,1,32'h200,lcafe, 1,0,32'h40,'0,  1, 0, a5, a5};
        tbl[4] = '{1,0,32'h200,'0, 0,0,32'h0,'0,     0, 0, lcafe, a5};
        tbl[5] = '{1,0,32'h100,'0, 1,0,32'h200,'0,   4, RR_MODE ? 1 : 0, l1234, lcafe};

        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        check_all_zero("reset");

        foreach (tbl[i]) begin
            serve(tbl[i], 1'b0, fw);
            check_i("tbl_first_winner", fw, tbl[i].first);
            check_w("tbl_data0", m0_data_o, tbl[i].exp0);
            check_w("tbl_data1", m1_data_o, tbl[i].exp1);
        end

        // Spurious memory ack while idle
        mem_ack_i = 1'b1;
        mem_data_i = rand_line();
        @(negedge clk);
        mem_ack_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check_b("spur_ack0", m0_ack_o, 1'b0);
            check_b("spur_ack1", m1_ack_o, 1'b0);
            check_b("spur_busy", busy_o, 1'b0);
            check_b("spur_enable", mem_enable_o, 1'b0);
            @(negedge clk);
        end

        // Reset three cycles into a transaction
        m0_req_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h80;
        wait_enable(n);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        drop_all();
        @(negedge clk);
        rst_i = 1'b0;
        check_all_zero("midrst");
        exp_d[0] = '0;
        exp_d[1] = '0;
        last_grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_b("midrst_noack0", m0_ack_o, 1'b0);
            check_b("midrst_noack1", m1_ack_o, 1'b0);
        end
        v = '{1,0,32'h80,'0, 0,0,32'h0,'0, 2, 0, '0, '0};
        serve(v, 1'b0, fw);
        check_w("postrst_data0", m0_data_o, {8{32'h80}});

        // Request held high through its ack is taken again after one idle cycle
        m0_req_i = 1'b1; m0_write_i = 1'b0; m0_addr_i = 32'h60;
        for (int k = 0; k < 2; k++) begin
            wait_enable(n);
            if (k == 1) check_i("held_gap", n, 1);
            check_a("held_addr", mem_addr_o, 32'h60);
            rd = ref_read(32'h60);
            mem_ack_i = 1'b1;
            mem_data_i = rd;
            @(negedge clk);
            mem_ack_i = 1'b0;
            exp_d[0] = rd;
            last_grant = 1'b0;
            check_b("held_ack", m0_ack_o, 1'b1);
            check_w("held_data", m0_data_o, rd);
            if (k == 1) m0_req_i = 1'b0;
            @(negedge clk);
            check_b("held_idle_busy", busy_o, 1'b0);
        end
        drop_all();
        @(negedge clk);

        // Random traffic against the model
        for (int t = 0; t < 40; t++) begin
            v.r0 = 1'($urandom_range(0, 1));
            v.r1 = 1'($urandom_range(0, 1));
            if (!v.r0 && !v.r1) v.r0 = 1'b1;
            v.w0 = 1'($urandom_range(0, 1));
            v.w1 = 1'($urandom_range(0, 1));
            v.a0 = 32'($urandom_range(0, 15)) << 5;
            v.a1 = 32'($urandom_range(0, 15)) << 5;
            v.d0 = rand_line();
            v.d1 = rand_line();
            v.lat = $urandom_range(0, 5);
            v.first = 0;
            v.exp0 = '0;
            v.exp1 = '0;
            serve(v, 1'b1, fw);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
